transaction_regfile: RTL and testbench
======================================

TRANSACTION_REGFILE -- requirements
Module: transaction_regfile

Interface
REQ-001 Parameter DEPTH, default 16: number of entries, power of two, 2..256.
REQ-002 Parameter WIDTH, default 32: data bits per entry, 1..64.
REQ-003 Parameter NREAD, default 3: combinational read ports, 1..4.
REQ-004 Parameter NWRITE, default 2: write ports, 1..4; AW = log2(DEPTH).
REQ-005 Port clk  in  1: single clock, all state on rising edge.
REQ-006 Port reset  in  1: asynchronous, active-low reset (low = in reset).
REQ-007 Port rd_adr  in  NREAD*AW: read addresses; port i occupies slice [i*AW +: AW].
REQ-008 Port rd_dat  out  NREAD*WIDTH: read data; port i occupies slice [i*WIDTH +: WIDTH].
REQ-009 Port wr_is  in  NWRITE: per-port write enables.
REQ-010 Port wr_adr  in  NWRITE*AW: write addresses.
REQ-011 Port wr_dat  in  NWRITE*WIDTH: write data.
REQ-012 Port clear_req  in  1: pulse that starts a full-array clear.
REQ-013 Port busy  out  1: high while the clear sweep runs.
REQ-014 Port dbg_addr_valid/dbg_addr_ready/dbg_addr_bits  in/out/in  1/1/AW: debug read request channel.
REQ-015 Port dbg_data_valid/dbg_data_ready/dbg_data_bits  out/in/out  1/1/WIDTH: debug read response channel.
REQ-016 Port conflict_cnt  out  8: saturating count of write-collision cycles.

Function
REQ-017 Reads are combinational: rd_dat[i] = mem[rd_adr[i]] in the same cycle; while busy=1, every rd_dat reads 0.
REQ-018 When busy=0, each write port with wr_is=1 updates mem[wr_adr] at the clock edge; ports writing different addresses all commit in the same cycle.
REQ-019 When two or more enabled ports share an address, the highest-index port's data is written; the others are discarded.
REQ-020 A collision cycle (at least one shared address among enabled ports, busy=0) increments conflict_cnt by 1; the count saturates at 255.
REQ-021 Clear FSM states: IDLE, CLEAR.
REQ-022 IDLE -> CLEAR on the first clock after reset release, or on clear_req=1 in IDLE.
REQ-023 CLEAR writes 0 to one entry per cycle, in order 0..DEPTH-1.
REQ-024 CLEAR -> IDLE after entry DEPTH-1 is written; the sweep lasts exactly DEPTH cycles.
REQ-025 busy = (state==CLEAR); clear_req received during CLEAR is ignored and does not restart the sweep.
REQ-026 While busy=1, all writes are dropped and no collisions are counted.
REQ-027 dbg_addr_ready = !busy && (!dbg_data_valid || dbg_data_ready).
REQ-028 When dbg_addr_valid and dbg_addr_ready are both high, mem[dbg_addr_bits] is registered into dbg_data_bits and dbg_data_valid=1 on the next cycle.
REQ-029 dbg_data_valid and dbg_data_bits hold stable until dbg_data_ready=1.
REQ-030 With dbg_data_valid=1 and dbg_data_ready=1, a new request in the same cycle is accepted, giving back-to-back responses at 1 per cycle.
REQ-031 The debug port samples the array value from before any same-cycle write.

Reset
REQ-032 reset low asynchronously forces: state=IDLE, busy=0, dbg_data_valid=0, dbg_data_bits=0, conflict_cnt=0.
REQ-033 Array contents are undefined during reset; the automatic post-reset sweep (REQ-022) zeroes them.
REQ-034 Reset asserted mid-sweep aborts the sweep; a new full sweep starts after release.

Configuration
REQ-035 Macro TRANSACTION_REGFILE_BYPASS_EN defined: when busy=0, a read whose address matches an enabled write returns that write data in the same cycle, using the winner per REQ-019; the debug port is not bypassed.
REQ-036 Macro not defined: reads return pre-write array contents and there is no forwarding logic.

Verification
REQ-037 Release reset -> busy=1 for exactly 16 cycles (default DEPTH), then busy=0; reading all addresses returns 0.
REQ-038 wr_is=2'b11, both addresses 5, port0=0xAAAA, port1=0x5555 -> mem[5]=0x5555 and conflict_cnt=1; 300 such cycles -> conflict_cnt=255.
REQ-039 Same-cycle write 0x1234 to addr 3 with rd_adr port0=3 -> rd_dat=0x1234 with the bypass macro, old value without it; 0x1234 on the next cycle in both builds.
REQ-040 Debug request to addr 7 (holding 0xC4F4) with dbg_data_ready=0 for 3 cycles -> dbg_data_valid=1 and 0xC4F4 held stable, dbg_addr_ready=0; ready high -> back-to-back requests to 7 and 8 give responses on consecutive cycles.
REQ-041 clear_req pulse, then reset asserted at sweep cycle 4 -> outputs at reset values immediately; after release, a full 16-cycle sweep runs; writes issued during busy have no effect.

Source files
------------

// File: rtl/transaction_regfile.sv
// Multi-port register file with a post-reset/on-demand clear sweep, collision counter and debug read channel.
// Define TRANSACTION_REGFILE_BYPASS_EN to forward same-cycle write data onto the combinational read ports.
module transaction_regfile #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 32,
  parameter int NREAD  = 3,
  parameter int NWRITE = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREAD*AW-1:0]     rd_adr,
  output logic [NREAD*WIDTH-1:0]  rd_dat,
  input  logic [NWRITE-1:0]       wr_is,
  input  logic [NWRITE*AW-1:0]    wr_adr,
  input  logic [NWRITE*WIDTH-1:0] wr_dat,
  input  logic                    clear_req,
  output logic                    busy,
  input  logic                    dbg_addr_valid,
  output logic                    dbg_addr_ready,
  input  logic [AW-1:0]           dbg_addr_bits,
  output logic                    dbg_data_valid,
  input  logic                    dbg_data_ready,
  output logic [WIDTH-1:0]        dbg_data_bits,
  output logic [7:0]              conflict_cnt,
  output logic [0:0]              fsm_state
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]       state;
  logic             start_pending;
  logic [AW-1:0]    clr_idx;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             collide;
  logic             dbg_fire;
  logic [WIDTH-1:0] rd_word;

  assign busy      = (state == ST_CLEAR);
  assign fsm_state = state;

  // Both debug channels are valid/ready: a transfer happens on any rising edge
  // where valid and ready are high together; a response holds until taken.
  assign dbg_addr_ready = !busy && (!dbg_data_valid || dbg_data_ready);
  assign dbg_fire       = dbg_addr_valid && dbg_addr_ready;

  always_comb begin
    collide = 1'b0;
    for (int i = 0; i < NWRITE; i++) begin
      for (int j = i + 1; j < NWRITE; j++) begin
        if (wr_is[i] && wr_is[j] && (wr_adr[i*AW +: AW] == wr_adr[j*AW +: AW]))
          collide = 1'b1;
      end
    end
  end

  // start_pending resets high so the first clock after release launches a sweep.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      start_pending <= 1'b1;
      clr_idx       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_pending || clear_req) begin
            state         <= ST_CLEAR;
            start_pending <= 1'b0;
            clr_idx       <= '0;
          end
        end
        ST_CLEAR: begin
          if (clr_idx == AW'(DEPTH - 1))
            state <= ST_IDLE;
          clr_idx <= clr_idx + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Later ports overwrite earlier ones, so the highest-index port wins a shared address.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[clr_idx] <= '0;
    end else begin
      for (int w = 0; w < NWRITE; w++) begin
        if (wr_is[w])
          mem[wr_adr[w*AW +: AW]] <= wr_dat[w*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflict_cnt   <= '0;
      dbg_data_valid <= 1'b0;
      dbg_data_bits  <= '0;
    end else begin
      if (!busy && collide && (conflict_cnt != 8'hFF))
        conflict_cnt <= conflict_cnt + 8'd1;
      if (dbg_fire) begin
        dbg_data_valid <= 1'b1;
        dbg_data_bits  <= mem[dbg_addr_bits];
      end else if (dbg_data_ready) begin
        dbg_data_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_dat  = '0;
    rd_word = '0;
    if (!busy) begin
      for (int r = 0; r < NREAD; r++) begin
        rd_word = mem[rd_adr[r*AW +: AW]];
`ifdef TRANSACTION_REGFILE_BYPASS_EN
        for (int w = 0; w < NWRITE; w++) begin
          if (wr_is[w] && (wr_adr[w*AW +: AW] == rd_adr[r*AW +: AW]))
            rd_word = wr_dat[w*WIDTH +: WIDTH];
        end
`endif
        rd_dat[r*WIDTH +: WIDTH] = rd_word;
      end
    end
  end

endmodule

// File: tb/tb_transaction_regfile.sv
// Directed-plus-random bench for transaction_regfile against an array/counter reference model.
module tb_transaction_regfile;
  localparam int DEPTH = 16;
  localparam int WIDTH = 32;
  localparam int NREAD = 3;
  localparam int NWRITE = 2;
  localparam int AW = 4;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic [NREAD*AW-1:0]     rd_adr;
  logic [NREAD*WIDTH-1:0]  rd_dat;
  logic [NWRITE-1:0]       wr_is;
  logic [NWRITE*AW-1:0]    wr_adr;
  logic [NWRITE*WIDTH-1:0] wr_dat;
  logic                    clear_req = 1'b0;
  logic                    busy;
  logic                    dbg_addr_valid = 1'b0;
  logic                    dbg_addr_ready;
  logic [AW-1:0]           dbg_addr_bits = '0;
  logic                    dbg_data_valid;
  logic                    dbg_data_ready = 1'b0;
  logic [WIDTH-1:0]        dbg_data_bits;
  logic [7:0]              conflict_cnt;
  logic [0:0]              fsm_state;

  logic [1:0]       w_en = 2'b00;
  logic [AW-1:0]    w_a [NWRITE];
  logic [WIDTH-1:0] w_d [NWRITE];
  logic [AW-1:0]    r_a [NREAD];

  logic [WIDTH-1:0] model_mem [DEPTH];
  int               model_cnt = 0;
  int               vectors = 0;
  int               miscompares = 0;

  assign wr_is  = w_en;
  assign wr_adr = {w_a[1], w_a[0]};
  assign wr_dat = {w_d[1], w_d[0]};
  assign rd_adr = {r_a[2], r_a[1], r_a[0]};

  transaction_regfile dut (
    .clk(clk), .reset(reset), .rd_adr(rd_adr), .rd_dat(rd_dat),
    .wr_is(wr_is), .wr_adr(wr_adr), .wr_dat(wr_dat), .clear_req(clear_req),
    .busy(busy), .dbg_addr_valid(dbg_addr_valid), .dbg_addr_ready(dbg_addr_ready),
    .dbg_addr_bits(dbg_addr_bits), .dbg_data_valid(dbg_data_valid),
    .dbg_data_ready(dbg_data_ready), .dbg_data_bits(dbg_data_bits),
    .conflict_cnt(conflict_cnt), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected combinational read: array contents, or the winning same-cycle write when forwarding is built in.
  function automatic logic [WIDTH-1:0] exp_rd(input logic [AW-1:0] a);
    logic [WIDTH-1:0] v;
    v = model_mem[a];
`ifdef TRANSACTION_REGFILE_BYPASS_EN
    for (int p = 0; p < NWRITE; p++)
      if (w_en[p] && w_a[p] == a) v = w_d[p];
`endif
    return v;
  endfunction

  task automatic commit_model();
    if (w_en == 2'b11 && w_a[0] == w_a[1] && model_cnt < 255) model_cnt++;
    for (int p = 0; p < NWRITE; p++)
      if (w_en[p]) model_mem[w_a[p]] = w_d[p];
  endtask

  task automatic zero_model();
    for (int a = 0; a < DEPTH; a++) model_mem[a] = '0;
  endtask

  // Starts at posedge+1 with inputs already driven; ends at the following posedge+1.
  task automatic run_cycle(input bit check_reads);
    @(negedge clk);
    if (check_reads)
      for (int r = 0; r < NREAD; r++)
        chk($sformatf("rd_dat%0d", r), 64'(rd_dat[r*WIDTH +: WIDTH]), 64'(exp_rd(r_a[r])));
    chk("conflict_cnt", 64'(conflict_cnt), 64'(model_cnt));
    commit_model();
    @(posedge clk);
    #1;
  endtask

  task automatic read_all(input string tag);
    w_en = 2'b00;
    for (int a = 0; a < DEPTH; a++) begin
      for (int r = 0; r < NREAD; r++) r_a[r] = AW'(a);
      @(negedge clk);
      chk(tag, 64'(rd_dat[WIDTH-1:0]), 64'(model_mem[a]));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_sweep(input string tag);
    int n;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (busy) n++;
      else if (n > 0) break;
    end
    chk(tag, 64'(n), 64'(DEPTH));
    zero_model();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] old9;
    int n;
    w_a[0] = '0; w_a[1] = '0; w_d[0] = '0; w_d[1] = '0;
    for (int r = 0; r < NREAD; r++) r_a[r] = '0;
    zero_model();

    // Reset values
    #1 reset = 1'b0;
    #11;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_dbg_valid", 64'(dbg_data_valid), 64'(0));
    chk("rst_dbg_bits", 64'(dbg_data_bits), 64'(0));
    chk("rst_conflict", 64'(conflict_cnt), 64'(0));
    @(posedge clk);
    #1 reset = 1'b1;
    wait_sweep("post_reset_sweep_len");
    read_all("post_reset_zero");

    // Random writes with collision bias, random reads checked against the model
    repeat (200) begin
      w_en = 2'($urandom_range(0, 3));
      w_a[0] = AW'($urandom_range(0, DEPTH - 1));
      w_a[1] = ($urandom_range(0, 3) == 0) ? w_a[0] : AW'($urandom_range(0, DEPTH - 1));
      w_d[0] = $urandom();
      w_d[1] = $urandom();
      for (int r = 0; r < NREAD; r++)
        r_a[r] = ($urandom_range(0, 1) == 1) ? w_a[$urandom_range(0, 1)] : AW'($urandom_range(0, DEPTH - 1));
      run_cycle(1'b1);
    end

    // Same-cycle write/read of address 3
    w_en = 2'b01; w_a[0] = 4'd3; w_d[0] = 32'h1234; r_a[0] = 4'd3;
    if (model_mem[3] == 32'h1234) model_mem[3] = 32'h0;
    run_cycle(1'b1);
    w_en = 2'b00;
    @(negedge clk);
    chk("rd_after_write", 64'(rd_dat[WIDTH-1:0]), 64'(32'h1234));
    @(posedge clk);
    #1;

    // Debug channel: stall, hold, back-to-back
    w_en = 2'b11; w_a[0] = 4'd7; w_d[0] = 32'hC4F4; w_a[1] = 4'd8; w_d[1] = 32'h8888_0008;
    run_cycle(1'b1);
    w_en = 2'b00;
    dbg_addr_valid = 1'b1; dbg_addr_bits = 4'd7; dbg_data_ready = 1'b0;
    @(negedge clk);
    chk("dbg_ready_idle", 64'(dbg_addr_ready), 64'(1));
    @(posedge clk);
    #1 dbg_addr_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("dbg_hold_valid", 64'(dbg_data_valid), 64'(1));
      chk("dbg_hold_bits", 64'(dbg_data_bits), 64'(32'hC4F4));
      chk("dbg_hold_ready", 64'(dbg_addr_ready), 64'(0));
      @(posedge clk);
      #1;
    end
    dbg_data_ready = 1'b1; dbg_addr_valid = 1'b1; dbg_addr_bits = 4'd7;
    @(negedge clk);
    chk("dbg_b2b_ready", 64'(dbg_addr_ready), 64'(1));
    @(posedge clk);
    #1 dbg_addr_bits = 4'd8;
    @(negedge clk);
    chk("dbg_b2b_valid0", 64'(dbg_data_valid), 64'(1));
    chk("dbg_b2b_bits0", 64'(dbg_data_bits), 64'(32'hC4F4));
    @(posedge clk);
    #1;
    old9 = model_mem[9];
    dbg_addr_bits = 4'd9; w_en = 2'b01; w_a[0] = 4'd9; w_d[0] = ~old9;
    @(negedge clk);
    chk("dbg_b2b_valid1", 64'(dbg_data_valid), 64'(1));
    chk("dbg_b2b_bits1", 64'(dbg_data_bits), 64'(32'h8888_0008));
    commit_model();
    @(posedge clk);
    #1 w_en = 2'b00; dbg_addr_valid = 1'b0;
    @(negedge clk);
    chk("dbg_prewrite_bits", 64'(dbg_data_bits), 64'(old9));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("dbg_drain_valid", 64'(dbg_data_valid), 64'(0));
    @(posedge clk);
    #1;

    // Guarantee a nonzero counter, then clear sweep aborted by reset at sweep cycle 4
    w_en = 2'b11; w_a[0] = 4'd2; w_a[1] = 4'd2; w_d[0] = 32'h1; w_d[1] = 32'h2;
    run_cycle(1'b1);
    w_en = 2'b00;
    clear_req = 1'b1;
    @(posedge clk);
    #1 clear_req = 1'b0;
    r_a[0] = 4'd7;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("clr_busy", 64'(busy), 64'(1));
      chk("clr_rd_zero", 64'(rd_dat[WIDTH-1:0]), 64'(0));
      chk("clr_dbg_ready", 64'(dbg_addr_ready), 64'(0));
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_dbg_valid", 64'(dbg_data_valid), 64'(0));
    chk("abort_dbg_bits", 64'(dbg_data_bits), 64'(0));
    chk("abort_conflict", 64'(conflict_cnt), 64'(0));
    model_cnt = 0;
    @(posedge clk);
    #1 reset = 1'b1;

    // Full sweep with dropped colliding writes and an ignored clear_req
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (busy) begin
        n++;
        if (n == 1) begin
          w_en = 2'b11; w_a[0] = 4'd0; w_a[1] = 4'd0; w_d[0] = 32'hFFFF; w_d[1] = 32'hEEEE;
          clear_req = 1'b1;
        end
        if (n == DEPTH) begin
          w_en = 2'b00;
          clear_req = 1'b0;
        end
      end else if (n > 0) break;
    end
    w_en = 2'b00;
    clear_req = 1'b0;
    chk("resweep_len", 64'(n), 64'(DEPTH));
    zero_model();
    @(posedge clk);
    #1;
    read_all("resweep_zero");
    chk("resweep_conflict", 64'(conflict_cnt), 64'(0));

    // Collision on address 5 and counter saturation
    w_en = 2'b11; w_a[0] = 4'd5; w_a[1] = 4'd5; w_d[0] = 32'hAAAA; w_d[1] = 32'h5555;
    run_cycle(1'b0);
    w_en = 2'b00; r_a[0] = 4'd5;
    run_cycle(1'b1);
    chk("collide_cnt1", 64'(conflict_cnt), 64'(1));
    w_en = 2'b11;
    repeat (299) run_cycle(1'b0);
    w_en = 2'b00;
    run_cycle(1'b1);
    chk("conflict_saturated", 64'(conflict_cnt), 64'(255));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
